// File: rtl/datamemory.sv
// RV32I data memory: byte-addressed, little-endian, synchronous stores with
// combinational funct3-formatted loads and a sticky flag for rejected stores.
module datamemory #(
    parameter int  DEPTH_WORDS = 1024,
    localparam int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Address,
    input  logic [31:0] DataRS2,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        Misaligned,
    output logic        MisalignFault
);

    logic [31:0]      mem_r [DEPTH_WORDS];
    logic             misalignFault_r;
    logic [IDX_W-1:0] wordIdx_s;
    logic [31:0]      rdWord_s;
    logic             isByte_s, isHalf_s, isWord_s, isUnsigned_s, illegal_s;
    logic             misaligned_s;
    logic [7:0]       rdByte_s;
    logic [15:0]      rdHalf_s;
    logic [31:0]      dataRd_s;
    logic [3:0]       byteEn_s;
    logic [31:0]      wrData_s;
    logic             wrEn_s;
    logic [31-IDX_W-2:0] addrUnused_s;

    // Sign- or zero-extend a loaded byte.
    function automatic logic [31:0] extByte(input logic [7:0] b, input logic uns);
        return uns ? {24'h000000, b} : {{24{b[7]}}, b};
    endfunction

    // Sign- or zero-extend a loaded halfword.
    function automatic logic [31:0] extHalf(input logic [15:0] h, input logic uns);
        return uns ? {16'h0000, h} : {{16{h[15]}}, h};
    endfunction

    // Upper address bits alias onto the same words and are deliberately dropped.
    assign addrUnused_s = Address[31:IDX_W+2];
    assign wordIdx_s    = Address[IDX_W+1:2];
    assign rdWord_s     = mem_r[wordIdx_s];

    // Decode funct3 into access width, extension and legality.
    always_comb begin
        isByte_s     = 1'b0;
        isHalf_s     = 1'b0;
        isWord_s     = 1'b0;
        isUnsigned_s = 1'b0;
        illegal_s    = 1'b0;
        case (DMCtrl)
            3'b000: isByte_s = 1'b1;
            3'b001: isHalf_s = 1'b1;
            3'b010: isWord_s = 1'b1;
            3'b100: begin
                isByte_s     = 1'b1;
                isUnsigned_s = 1'b1;
                illegal_s    = DMWr;   // no unsigned store exists
            end
            3'b101: begin
                isHalf_s     = 1'b1;
                isUnsigned_s = 1'b1;
                illegal_s    = DMWr;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    assign misaligned_s = illegal_s
                        | (isHalf_s & Address[0])
                        | (isWord_s & (Address[1:0] != 2'b00));

    // Pick the addressed lane(s) and format the load result.
    always_comb begin
        rdByte_s = 8'h00;
        rdHalf_s = 16'h0000;
        dataRd_s = 32'h0000_0000;
        case (Address[1:0])
            2'b00:   rdByte_s = rdWord_s[7:0];
            2'b01:   rdByte_s = rdWord_s[15:8];
            2'b10:   rdByte_s = rdWord_s[23:16];
            2'b11:   rdByte_s = rdWord_s[31:24];
            default: rdByte_s = 8'h00;
        endcase
        if (Address[1]) begin
            rdHalf_s = rdWord_s[31:16];
        end else begin
            rdHalf_s = rdWord_s[15:0];
        end
        if (misaligned_s) begin
            dataRd_s = 32'h0000_0000;
        end else if (isByte_s) begin
            dataRd_s = extByte(rdByte_s, isUnsigned_s);
        end else if (isHalf_s) begin
            dataRd_s = extHalf(rdHalf_s, isUnsigned_s);
        end else begin
            dataRd_s = rdWord_s;
        end
    end

    // Replicate store data across lanes and form the byte-enable mask.
    always_comb begin
        byteEn_s = 4'b0000;
        wrData_s = DataRS2;
        if (isByte_s) begin
            byteEn_s = 4'b0001 << Address[1:0];
            wrData_s = {4{DataRS2[7:0]}};
        end else if (isHalf_s) begin
            byteEn_s = Address[1] ? 4'b1100 : 4'b0011;
            wrData_s = {2{DataRS2[15:0]}};
        end else if (isWord_s) begin
            byteEn_s = 4'b1111;
            wrData_s = DataRS2;
        end else begin
            byteEn_s = 4'b0000;
            wrData_s = DataRS2;
        end
    end

    assign wrEn_s = DMWr & ~misaligned_s;

    // Storage array: cleared on reset, lane-masked writes otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (wrEn_s) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn_s[b]) begin
                    mem_r[wordIdx_s][8*b +: 8] <= wrData_s[8*b +: 8];
                end
            end
        end
    end

    // Sticky record of any store that was rejected; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalignFault_r <= 1'b0;
        end else if (DMWr && misaligned_s) begin
            misalignFault_r <= 1'b1;
        end else begin
            misalignFault_r <= misalignFault_r;
        end
    end

    assign DataRd        = dataRd_s;
    assign Misaligned    = misaligned_s;
    assign MisalignFault = misalignFault_r;

endmodule

// File: tb/tb_datamemory.sv
// Scoreboard bench for datamemory: expected load results are queued as each
// access is driven and compared once the combinational outputs settle.
module tb_datamemory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] DataRS2 = 32'h0;
    logic        DMWr = 1'b0;
    logic [2:0]  DMCtrl = 3'b010;
    logic [31:0] DataRd;
    logic        Misaligned;
    logic        MisalignFault;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] refMem [1024];
    logic        refFault = 1'b0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        mis;
    } exp_t;
    exp_t sbQ[$];

    datamemory dut (
        .clk(clk), .rst_n(rst_n), .Address(Address), .DataRS2(DataRS2),
        .DMWr(DMWr), .DMCtrl(DMCtrl), .DataRd(DataRd),
        .Misaligned(Misaligned), .MisalignFault(MisalignFault)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nCompared++;
        if (obs !== expv) begin
            nMismatched++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, expv);
        end
    endtask

    function automatic logic modelMis(input logic [2:0] ctrl, input logic [31:0] addr, input logic wr);
        case (ctrl)
            3'b000:  return 1'b0;
            3'b001:  return addr[0];
            3'b010:  return addr[1:0] != 2'b00;
            3'b100:  return wr;
            3'b101:  return wr | addr[0];
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] ctrl, input logic [31:0] addr, input logic wr);
        logic [31:0] w, b, h;
        if (modelMis(ctrl, addr, wr)) return 32'h0;
        w = refMem[addr[11:2]];
        b = (w >> (8 * addr[1:0])) & 32'hFF;
        h = (w >> (16 * addr[1])) & 32'hFFFF;
        case (ctrl)
            3'b000:  return (b[7]  ? (b | 32'hFFFF_FF00) : b);
            3'b001:  return (h[15] ? (h | 32'hFFFF_0000) : h);
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic popCheck();
        exp_t e;
        if (sbQ.size() == 0) begin
            checkVal("sb_empty", 32'h1, 32'h0);
        end else begin
            e = sbQ.pop_front();
            checkVal({e.tag, ".data"}, DataRd, e.data);
            checkVal({e.tag, ".mis"}, {31'b0, Misaligned}, {31'b0, e.mis});
        end
    endtask

    task automatic checkFault(input string tag);
        checkVal(tag, {31'b0, MisalignFault}, {31'b0, refFault});
    endtask

    task automatic load(input string tag, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] expData, input logic expMis);
        @(negedge clk);
        DMWr = 1'b0; DMCtrl = ctrl; Address = addr;
        sbQ.push_back('{tag, expData, expMis});
        #1 popCheck();
    endtask

    task automatic loadModel(input string tag, input logic [2:0] ctrl, input logic [31:0] addr);
        load(tag, ctrl, addr, modelLoad(ctrl, addr, 1'b0), modelMis(ctrl, addr, 1'b0));
    endtask

    // Drive a store; check the pre-edge (old) read, then the post-edge read.
    task automatic store(input string tag, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] data);
        logic mis;
        @(negedge clk);
        DMWr = 1'b1; DMCtrl = ctrl; Address = addr; DataRS2 = data;
        mis = modelMis(ctrl, addr, 1'b1);
        sbQ.push_back('{{tag, ".pre"}, modelLoad(ctrl, addr, 1'b1), mis});
        #1 popCheck();
        @(posedge clk);
        if (mis) begin
            refFault = 1'b1;
        end else begin
            case (ctrl)
                3'b000:  refMem[addr[11:2]][8*addr[1:0] +: 8] = data[7:0];
                3'b001:  refMem[addr[11:2]][16*addr[1] +: 16] = data[15:0];
                default: refMem[addr[11:2]] = data;
            endcase
        end
        sbQ.push_back('{{tag, ".post"}, modelLoad(ctrl, addr, 1'b1), mis});
        #1 popCheck();
        checkFault({tag, ".fault"});
        DMWr = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 1024; i++) refMem[i] = 32'h0;
        refFault = 1'b0;
        #1 checkFault("rst.fault");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) refMem[i] = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        load("rst_lw", 3'b010, 32'h00, 32'h0, 1'b0);
        checkFault("rst_fault");

        store("sw10", 3'b010, 32'h10, 32'hDEAD_BEEF);
        load("lw10",  3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0);
        load("lb13",  3'b000, 32'h13, 32'hFFFF_FFDE, 1'b0);
        load("lbu13", 3'b100, 32'h13, 32'h0000_00DE, 1'b0);
        load("lh10",  3'b001, 32'h10, 32'hFFFF_BEEF, 1'b0);
        load("lhu12", 3'b101, 32'h12, 32'h0000_DEAD, 1'b0);

        store("sb11", 3'b000, 32'h11, 32'h0000_00AA);
        load("lw10b", 3'b010, 32'h10, 32'hDEAD_AAEF, 1'b0);
        store("sh12", 3'b001, 32'h12, 32'hFFFF_1234);
        load("lw10c", 3'b010, 32'h10, 32'h1234_AAEF, 1'b0);

        store("sw22mis", 3'b010, 32'h22, 32'h1111_1111);
        load("lw20", 3'b010, 32'h20, 32'h0, 1'b0);
        store("sw20", 3'b010, 32'h20, 32'h2222_2222);
        load("lw20b", 3'b010, 32'h20, 32'h2222_2222, 1'b0);

        load("ill011", 3'b011, 32'h10, 32'h0, 1'b1);
        load("lh11",   3'b001, 32'h11, 32'h0, 1'b1);

        pulseReset();
        checkFault("fault_cleared");
        store("sbu30", 3'b100, 32'h30, 32'h7777_7777);
        load("lw30", 3'b010, 32'h30, 32'h0, 1'b0);

        pulseReset();
        store("sw1000", 3'b010, 32'h1000, 32'h0000_0055);
        load("lw0wrap", 3'b010, 32'h0000, 32'h0000_0055, 1'b0);

        // Asynchronous reset between edges, then a store attempted during reset.
        #1 rst_n = 1'b0;
        sbQ.push_back('{"rst_async", 32'h0, 1'b0});
        #1 popCheck();
        for (int i = 0; i < 1024; i++) refMem[i] = 32'h0;
        refFault = 1'b0;
        DMWr = 1'b1; DataRS2 = 32'h0000_0099;
        @(posedge clk);
        #1 DMWr = 1'b0;
        sbQ.push_back('{"rst_nowrite", 32'h0, 1'b0});
        popCheck();
        @(negedge clk);
        rst_n = 1'b1;

        // Random mix of stores and loads against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [2:0]  c;
            logic [31:0] a;
            case ($urandom_range(0, 5))
                0: c = 3'b000;
                1: c = 3'b001;
                2: c = 3'b010;
                3: c = 3'b100;
                4: c = 3'b101;
                default: c = 3'b011;
            endcase
            a = {$urandom_range(0, 3) == 0 ? 20'h0_0001 : 20'h0, 6'h0, 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 1) == 1) begin
                store($sformatf("rnd%0d_st", n), c, a, $urandom);
            end else begin
                loadModel($sformatf("rnd%0d_ld", n), c, a);
            end
        end
        for (int k = 0; k < 16; k++) begin
            loadModel($sformatf("sweep%0d", k), 3'b010, 32'(k * 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
